// File: rtl/axi_pkg.sv
// axi_pkg: shared types and constants for the AXI read responder
package axi_pkg;
  localparam int AXI_ADDR_MAX = 64;
  localparam int AXI_ID_MAX = 16;
  localparam logic [1:0] RRESP_OKAY = 2'b00;
  typedef enum logic {S_IDLE, S_BURST} burst_state_t;
  typedef struct packed {
    logic [AXI_ADDR_MAX-1:0] addr;
    logic [7:0]              len;
    logic [AXI_ID_MAX-1:0]   id;
  } ar_req_t;
endpackage

// File: rtl/axi_ar_fifo.sv
// axi_ar_fifo: synchronous FIFO holding accepted AR requests in arrival order
module axi_ar_fifo
  import axi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  ar_req_t din,
  input  logic    pop,
  output ar_req_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  ar_req_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  // pointer pair with an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + ONE;
      if (pop && !empty) rp <= rp + ONE;
    end
  // request storage; contents are meaningless until pointed at, so no reset
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/axi_read_responder.sv
// axi_read_responder: AXI INCR read slave streaming beats from a 1-cycle-latency memory
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 64,
  parameter int C_DATA_WIDTH = 512,
  parameter int C_ID_WIDTH = 4,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 arvalid,
  output logic                                 arready,
  input  logic [C_ADDR_WIDTH-1:0]              araddr,
  input  logic [7:0]                           arlen,
  input  logic [C_ID_WIDTH-1:0]                arid,
  output logic                                 rvalid,
  input  logic                                 rready,
  output logic [C_DATA_WIDTH-1:0]              rdata,
  output logic                                 rlast,
  output logic [C_ID_WIDTH-1:0]                rid,
  output logic [1:0]                           rresp,
  output logic                                 mem_rd_en,
  output logic [C_ADDR_WIDTH-1:0]              mem_rd_addr,
  input  logic [C_DATA_WIDTH-1:0]              mem_rd_data,
  output logic [$clog2(C_MAX_OUTSTANDING):0]   outstanding,
  output logic                                 idle
);
  localparam int OW = $clog2(C_MAX_OUTSTANDING) + 1;
  localparam logic [AXI_ADDR_MAX-1:0] STRIDE = AXI_ADDR_MAX'(C_DATA_WIDTH / 8);
  ar_req_t ar_in, head;
  logic full, empty, pop, ar_hs, r_hs;
  burst_state_t state, state_nx;
  logic [AXI_ADDR_MAX-1:0] cur_addr, addr_nx, src_addr;
  logic [7:0] cur_len, len_nx, src_len;
  logic [AXI_ID_MAX-1:0] cur_id, id_nx, src_id;
  logic has_src, issue, last_beat, inflight, tag_last;
  logic [C_ID_WIDTH-1:0] tag_id;
  logic [1:0] buf_cnt, occ;
  logic bwp, brp;
  logic [C_DATA_WIDTH-1:0] b_data [2];
  logic b_last [2];
  logic [C_ID_WIDTH-1:0] b_id [2];
  logic unused_hi;
  assign ar_hs = arvalid && arready;
  assign r_hs = rvalid && rready;
  assign arready = rst_n && !full && (outstanding != OW'(C_MAX_OUTSTANDING));
  assign ar_in = '{addr: AXI_ADDR_MAX'(araddr), len: arlen, id: AXI_ID_MAX'(arid)};
  axi_ar_fifo #(.DEPTH(C_MAX_OUTSTANDING)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(ar_hs), .din(ar_in),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );
  // IDLE issues beat 0 straight from the queue head to keep AR-to-read latency at one cycle
  assign src_addr = state == S_BURST ? cur_addr : head.addr;
  assign src_len = state == S_BURST ? cur_len : head.len;
  assign src_id = state == S_BURST ? cur_id : head.id;
  assign has_src = state == S_BURST || !empty;
  // occupancy counts the beat leaving this cycle so full rate is kept without overflowing the buffer
  assign occ = buf_cnt + 2'(inflight) - 2'(r_hs);
  assign issue = has_src && !occ[1];
  assign last_beat = src_len == 8'd0;
  assign pop = issue && (state == S_IDLE || (last_beat && !empty));
  assign mem_rd_en = issue;
  assign mem_rd_addr = src_addr[C_ADDR_WIDTH-1:0];
  assign unused_hi = ^{src_addr, src_id};
  // next burst context: advance within a burst, chain to the next head, or fall back to IDLE
  always_comb begin
    state_nx = state;
    addr_nx = cur_addr;
    len_nx = cur_len;
    id_nx = cur_id;
    if (issue) begin
      if (!last_beat) begin
        state_nx = S_BURST;
        addr_nx = src_addr + STRIDE;
        len_nx = src_len - 8'd1;
        id_nx = src_id;
      end else if (state == S_BURST && !empty) begin
        state_nx = S_BURST;
        addr_nx = head.addr;
        len_nx = head.len;
        id_nx = head.id;
      end else state_nx = S_IDLE;
    end
  end
  // burst state and in-flight tracking
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      inflight <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= issue;
    end
  // burst context and beat tags only matter once state/inflight say so
  always_ff @(posedge clk) begin
    cur_addr <= addr_nx;
    cur_len <= len_nx;
    cur_id <= id_nx;
    tag_last <= last_beat;
    tag_id <= src_id[C_ID_WIDTH-1:0];
  end
  // output buffer pointers, occupancy and outstanding-burst count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bwp <= 1'b0;
      brp <= 1'b0;
      buf_cnt <= 2'd0;
      outstanding <= '0;
    end else begin
      if (inflight) bwp <= ~bwp;
      if (r_hs) brp <= ~brp;
      buf_cnt <= buf_cnt + 2'(inflight) - 2'(r_hs);
      outstanding <= outstanding + OW'(ar_hs) - OW'(r_hs && rlast);
    end
  // capture returning memory data with its tags
  always_ff @(posedge clk)
    if (inflight) begin
      b_data[bwp] <= mem_rd_data;
      b_last[bwp] <= tag_last;
      b_id[bwp] <= tag_id;
    end
  assign rvalid = buf_cnt != 2'd0;
  assign rdata = b_data[brp];
  assign rlast = rvalid && b_last[brp];
  assign rid = b_id[brp];
  assign rresp = RRESP_OKAY;
  assign idle = outstanding == '0 && !inflight;
endmodule

// File: tb/tb_axi_read_responder.sv
// tb_axi_read_responder: directed and randomized checks against a burst-level reference model
module tb_axi_read_responder;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int IW = 4;
  localparam int MO = 16;
  localparam int OW = 5;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] id;
    int            cyc;
  } got_t;
  logic clk = 1'b0;
  logic rst_n;
  logic arvalid, arready, rvalid, rready, rlast, mem_rd_en, idle;
  logic [AW-1:0] araddr, mem_rd_addr;
  logic [7:0] arlen;
  logic [IW-1:0] arid, rid;
  logic [DW-1:0] rdata, mem_rd_data;
  logic [1:0] rresp;
  logic [OW-1:0] outstanding;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int ar_cyc = 0;
  bit rmode = 0;
  beat_t exp_q[$];
  got_t got_q[$];
  logic [AW-1:0] rd_q[$];
  int rdc_q[$];
  always #5 clk = ~clk;
  axi_read_responder #(
    .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_ID_WIDTH(IW), .C_MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arlen(arlen), .arid(arid), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rlast(rlast), .rid(rid), .rresp(rresp), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .outstanding(outstanding),
    .idle(idle)
  );
  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32+:32] = a[31:0] ^ a[63:32] ^ (32'h9E3779B1 * 32'(i + 1));
    return r;
  endfunction
  // memory with one-cycle read latency
  always @(posedge clk) mem_rd_data <= mem_rd_en ? memfn(mem_rd_addr) : '0;
  task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    beat_t b;
    int n;
    #1;
    if (arvalid && arready) begin
      for (int k = 0; k <= int'(arlen); k++) begin
        b.addr = araddr + AW'(k) * AW'(DW / 8);
        b.data = memfn(b.addr);
        b.last = k == int'(arlen);
        b.id = arid;
        exp_q.push_back(b);
      end
      n_acc++;
      ar_cyc = cyc;
    end
    if (mem_rd_en) begin
      rd_q.push_back(mem_rd_addr);
      rdc_q.push_back(cyc);
    end
    if (rvalid) begin
      n = got_q.size();
      if (n < exp_q.size())
        check("r_beat", 576'({rdata, rlast, rid, rresp}), 576'({exp_q[n].data, exp_q[n].last, exp_q[n].id, 2'b00}));
      else check("r_extra_beat", 576'(n), 576'(exp_q.size()));
    end
    if (rvalid && rready) got_q.push_back('{rdata, rlast, rid, cyc});
    @(negedge clk);
    cyc++;
    if (rmode) rready = 1'($urandom_range(0, 1));
  endtask
  task automatic send_ar(input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] i);
    int n0;
    n0 = n_acc;
    araddr = a;
    arlen = l;
    arid = i;
    arvalid = 1'b1;
    for (int t = 0; t < 64 && n_acc == n0; t++) tick();
    arvalid = 1'b0;
    check("ar_accept", 576'(n_acc - n0), 576'(1));
  endtask
  task automatic drain();
    for (int t = 0; t < 3000 && got_q.size() < exp_q.size(); t++) tick();
  endtask
  task automatic flush();
    exp_q.delete();
    got_q.delete();
    rd_q.delete();
    rdc_q.delete();
  endtask
  task automatic compare_all(input string tag);
    check({tag, "_beats"}, 576'(got_q.size()), 576'(exp_q.size()));
    check({tag, "_reads"}, 576'(rd_q.size()), 576'(exp_q.size()));
    for (int i = 0; i < rd_q.size() && i < exp_q.size(); i++)
      check({tag, "_rd_addr"}, 576'(rd_q[i]), 576'(exp_q[i].addr));
    check({tag, "_outstanding"}, 576'(outstanding), 576'(0));
    check({tag, "_idle"}, 576'(idle), 576'(1));
    flush();
  endtask
  function automatic logic [AW-1:0] rand_addr();
    return {32'($urandom), 32'($urandom)} & ~64'h3F;
  endfunction
  initial begin
    int t0, n0;
    rst_n = 1'b0;
    arvalid = 1'b0;
    araddr = '0;
    arlen = '0;
    arid = '0;
    rready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_arready", 576'(arready), 576'(0));
    check("rst_rvalid", 576'(rvalid), 576'(0));
    check("rst_mem_rd_en", 576'(mem_rd_en), 576'(0));
    check("rst_rlast", 576'(rlast), 576'(0));
    check("rst_outstanding", 576'(outstanding), 576'(0));
    check("rst_idle", 576'(idle), 576'(1));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_arready", 576'(arready), 576'(1));
    // single 4-beat burst: addresses, timing, tags
    rready = 1'b1;
    send_ar(64'h1000, 8'd3, 4'd5);
    t0 = ar_cyc;
    drain();
    for (int i = 0; i < 4; i++)
      check("rd_cycle", 576'(i < rdc_q.size() ? rdc_q[i] : -1), 576'(t0 + 1 + i));
    check("first_rvalid_cycle", 576'(got_q.size() > 0 ? got_q[0].cyc : -1), 576'(t0 + 3));
    compare_all("single");
    // single-beat burst and outstanding decrement on its handshake
    rready = 1'b0;
    send_ar(64'h0, 8'd0, 4'd2);
    for (int t = 0; t < 10 && !rvalid; t++) tick();
    check("len0_outstanding_pre", 576'(outstanding), 576'(1));
    check("len0_rlast", 576'(rlast), 576'(1));
    rready = 1'b1;
    tick();
    check("len0_outstanding_post", 576'(outstanding), 576'(0));
    compare_all("len0");
    // fill all outstanding slots with R stalled
    rready = 1'b0;
    for (int i = 0; i < MO; i++) send_ar(rand_addr(), 8'($urandom_range(0, 3)), 4'($urandom));
    check("fill_arready", 576'(arready), 576'(0));
    check("fill_outstanding", 576'(outstanding), 576'(MO));
    check("fill_idle", 576'(idle), 576'(0));
    check("fill_reads_le2", 576'(rd_q.size() <= 2), 576'(1));
    n0 = n_acc;
    araddr = rand_addr();
    arlen = 8'd0;
    arvalid = 1'b1;
    repeat (4) tick();
    arvalid = 1'b0;
    check("fill_blocked", 576'(n_acc), 576'(n0));
    rready = 1'b1;
    drain();
    compare_all("fill");
    // random backpressure over 8 random bursts plus one address-wrapping burst
    rmode = 1'b1;
    for (int i = 0; i < 8; i++) send_ar(rand_addr(), 8'($urandom_range(0, 15)), 4'($urandom));
    send_ar(64'hFFFF_FFFF_FFFF_FFC0, 8'd2, 4'hA);
    drain();
    rmode = 1'b0;
    rready = 1'b1;
    compare_all("random");
    // AR accepted in the same cycle as the final rlast handshake
    send_ar(64'h3000, 8'd1, 4'd3);
    for (int t = 0; t < 20 && !(rvalid && rlast); t++) tick();
    check("overlap_rlast_ready", 576'(rvalid && rlast), 576'(1));
    check("overlap_outstanding_pre", 576'(outstanding), 576'(1));
    n0 = n_acc;
    araddr = 64'h4000;
    arlen = 8'd2;
    arid = 4'd6;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("overlap_accepted", 576'(n_acc - n0), 576'(1));
    check("overlap_outstanding_post", 576'(outstanding), 576'(1));
    drain();
    compare_all("overlap");
    // reset in the middle of an 8-beat burst
    send_ar(64'h8000, 8'd7, 4'd7);
    for (int t = 0; t < 30 && got_q.size() < 2; t++) tick();
    check("midrst_progress", 576'(got_q.size()), 576'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", 576'(rvalid), 576'(0));
    check("midrst_mem_rd_en", 576'(mem_rd_en), 576'(0));
    check("midrst_outstanding", 576'(outstanding), 576'(0));
    check("midrst_idle", 576'(idle), 576'(1));
    check("midrst_arready", 576'(arready), 576'(0));
    check("midrst_rlast", 576'(rlast), 576'(0));
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_rel_arready", 576'(arready), 576'(1));
    send_ar(64'h2000, 8'd1, 4'd9);
    drain();
    compare_all("post_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
